// File: rtl/pixel_add_pipe_pkg.sv
// Shared constants, pipeline record types and IMPLY-gate helpers for pixel_add_pipe.
package pixel_add_pipe_pkg;

  localparam int PIX_W = 8;

  localparam logic MODE_ADD_SAT = 1'b0;
  localparam logic MODE_AVG     = 1'b1;

  localparam logic [PIX_W-1:0] PIX_MAX = 8'hFF;

  typedef struct packed {
    logic [PIX_W-1:0] a;
    logic [PIX_W-1:0] b;
    logic             mode;
  } opnd_t;

  // Material implication p -> q; every other gate of the adder core is built from it.
  function automatic logic imp(input logic p, input logic q);
    return ~p | q;
  endfunction

  function automatic logic imp_not(input logic p);
    return imp(p, 1'b0);
  endfunction

  function automatic logic imp_or(input logic p, input logic q);
    return imp(imp_not(p), q);
  endfunction

  function automatic logic imp_and(input logic p, input logic q);
    return imp_not(imp(p, imp_not(q)));
  endfunction

  function automatic logic imp_xor(input logic p, input logic q);
    return imp_and(imp_or(p, q), imp_not(imp_and(p, q)));
  endfunction

endpackage

// File: rtl/pixel_add_pipe_rca.sv
// IMPLY-logic 8-bit ripple-carry adder core; purely combinational, one carry hop per bit.
module pixel_add_pipe_rca
  import pixel_add_pipe_pkg::*;
(
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic             cin_i,
  output logic [PIX_W-1:0] sum_o,
  output logic             cout_o
);

  logic carry_c;
  logic prop_c;

  always_comb begin
    carry_c = cin_i;
    prop_c  = 1'b0;
    sum_o   = '0;
    for (int i = 0; i < PIX_W; i++) begin
      prop_c   = imp_xor(a_i[i], b_i[i]);
      sum_o[i] = imp_xor(prop_c, carry_c);
      carry_c  = imp_or(imp_and(a_i[i], b_i[i]), imp_and(prop_c, carry_c));
    end
    cout_o = carry_c;
  end

endmodule

// File: rtl/pixel_add_pipe.sv
// Two-stage streaming pixel adder (saturating add / rounded average) with end-of-line marking.
// Optional clamp-event counter enabled by defining PIX_ADD_SAT_CNT_EN.
module pixel_add_pipe
  import pixel_add_pipe_pkg::*;
#(
  parameter int LINE_W = 640
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_a,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_sat,
`ifdef PIX_ADD_SAT_CNT_EN
  output logic [15:0]      sat_cnt,
  input  logic             sat_cnt_clr,
`endif
  output logic             out_eol
);

  localparam int CNT_W = $clog2(LINE_W);
  localparam logic [CNT_W-1:0] POS_LAST = CNT_W'(LINE_W - 1);

  logic             v1_q, v1_d;
  opnd_t            opnd_q, opnd_d;
  logic             v2_q, v2_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] pos_q, pos_d;

  logic             adv1, adv2, out_hs;
  logic [PIX_W-1:0] core_sum;
  logic             core_cout;
  logic [PIX_W-1:0] res_pix;
  logic             res_sat;

  // Handshake: a transfer happens on a rising edge where valid && ready; a source
  // holds valid and its data until that edge, and ready never waits on valid.
  assign adv2     = !v2_q || out_ready;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;
  assign out_hs   = v2_q && out_ready;

  pixel_add_pipe_rca u_rca (
    .a_i    (opnd_q.a),
    .b_i    (opnd_q.b),
    .cin_i  (opnd_q.mode),
    .sum_o  (core_sum),
    .cout_o (core_cout)
  );

  // Averaging rides on Cin = 1, so {Cout, Sum[7:1]} is the rounded-up half.
  always_comb begin
    if (opnd_q.mode == MODE_AVG) begin
      res_pix = {core_cout, core_sum[PIX_W-1:1]};
      res_sat = 1'b0;
    end else begin
      res_pix = core_cout ? PIX_MAX : core_sum;
      res_sat = core_cout;
    end
  end

  always_comb begin
    v1_d   = v1_q;
    opnd_d = opnd_q;
    v2_d   = v2_q;
    pix_d  = pix_q;
    sat_d  = sat_q;
    pos_d  = pos_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) opnd_d = '{a: in_a, b: in_b, mode: in_mode};
    end
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        pix_d = res_pix;
        sat_d = res_sat;
      end
    end
    if (out_hs) pos_d = (pos_q == POS_LAST) ? '0 : pos_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      opnd_q <= '0;
      v2_q   <= 1'b0;
      pix_q  <= '0;
      sat_q  <= 1'b0;
      pos_q  <= '0;
    end else begin
      v1_q   <= v1_d;
      opnd_q <= opnd_d;
      v2_q   <= v2_d;
      pix_q  <= pix_d;
      sat_q  <= sat_d;
      pos_q  <= pos_d;
    end
  end

  assign out_valid = v2_q;
  assign out_pix   = pix_q;
  assign out_sat   = sat_q;
  assign out_eol   = v2_q && (pos_q == POS_LAST);

`ifdef PIX_ADD_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  // Clear wins over a same-edge increment; the count sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (sat_cnt_clr) sat_cnt_d = '0;
    else if (out_hs && sat_q && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sat_cnt_q <= '0;
    else     sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: tb/tb_pixel_add_pipe.sv
// Bench for pixel_add_pipe (LINE_W = 4): vector table, scoreboarded streams, stall/reset/EOL sequences.
module tb_pixel_add_pipe;

  localparam int LINE_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_mode = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_pix;
  logic       out_sat;
  logic       out_eol;
`ifdef PIX_ADD_SAT_CNT_EN
  logic [15:0] sat_cnt;
  logic        sat_cnt_clr = 1'b0;
`endif

  pixel_add_pipe #(.LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_sat   (out_sat),
`ifdef PIX_ADD_SAT_CNT_EN
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr),
`endif
    .out_eol   (out_eol)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];  // {pix, sat, eol}
  int   checks    = 0;
  int   errors    = 0;
  int   model_pos = 0;
  int   eol_seen  = 0;
  int   out_cnt   = 0;
  logic saw_block = 1'b0;
  logic stall     = 1'b0;
  logic [10:0] held = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [7:0] exp_pix;
    logic       exp_sat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
    int s;
    s = int'(a) + int'(b);
    if (m) return {8'((s + 1) / 2), 1'b0};
    if (s > 255) return {8'd255, 1'b1};
    return {8'(s), 1'b0};
  endfunction

  task automatic push_exp(input logic [7:0] pix, input logic sat);
    exp_q.push_back({pix, sat, logic'(model_pos == LINE_W - 1)});
    model_pos = (model_pos == LINE_W - 1) ? 0 : model_pos + 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic m,
                      input logic [7:0] pix, input logic sat);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_mode  = m;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push_exp(pix, sat);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] a, input logic [7:0] b, input logic m);
    logic [8:0] r;
    r = model(a, b, m);
    send(a, b, m, r[8:1], r[0]);
  endtask

  task automatic send_rand();
    send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (out_ready) check("in_ready_with_out_ready", 32'(in_ready), 32'd1);
      if (!in_ready) saw_block = 1'b1;
      if (stall) check("held_output", 32'({out_valid, out_pix, out_sat, out_eol}), 32'(held));
      if (out_valid && out_ready) begin
        out_cnt++;
        if (out_eol) eol_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_pix_sat_eol", 32'({out_pix, out_sat, out_eol}), 32'(e));
        end
      end
      stall = out_valid && !out_ready;
      held  = {out_valid, out_pix, out_sat, out_eol};
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    vecs[0]  = '{8'd200, 8'd100, 1'b0, 8'd255, 1'b1};
    vecs[1]  = '{8'd100, 8'd55,  1'b0, 8'd155, 1'b0};
    vecs[2]  = '{8'd200, 8'd100, 1'b1, 8'd150, 1'b0};
    vecs[3]  = '{8'd255, 8'd254, 1'b1, 8'd255, 1'b0};
    vecs[4]  = '{8'd0,   8'd1,   1'b1, 8'd1,   1'b0};
    vecs[5]  = '{8'd128, 8'd127, 1'b0, 8'd255, 1'b0};
    vecs[6]  = '{8'd128, 8'd128, 1'b0, 8'd255, 1'b1};
    vecs[7]  = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0};
    vecs[8]  = '{8'd255, 8'd255, 1'b1, 8'd255, 1'b0};
    vecs[9]  = '{8'd0,   8'd0,   1'b1, 8'd0,   1'b0};
    vecs[10] = '{8'd3,   8'd4,   1'b1, 8'd4,   1'b0};
    vecs[11] = '{8'd255, 8'd1,   1'b0, 8'd255, 1'b1};

    // reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_pix",   32'(out_pix),   32'd0);
    check("rst_out_sat",   32'(out_sat),   32'd0);
    check("rst_out_eol",   32'(out_eol),   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // latency: accepted at edge k, valid in the cycle after edge k+1
    send(8'd200, 8'd100, 1'b0, 8'd255, 1'b1);
    @(negedge clk);
    check("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("latency_pix",   32'(out_pix),   32'd255);
    drain();

    // vector table, back to back
    for (int i = 0; i < 12; i++) send(vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].exp_pix, vecs[i].exp_sat);
    drain();

    for (int i = 0; i < 20; i++) send_rand();
    drain();

    // backpressure mid-stream
    saw_block = 1'b0;
    n0 = out_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_in_ready_dropped", 32'(saw_block), 32'd1);
    check("bp_output_count", 32'(out_cnt - n0), 32'd10);

    // reset with both stages full
    out_ready = 1'b0;
    send_rand();
    send_rand();
    @(negedge clk);
    check("pre_rst_full", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    exp_q.delete();
    model_pos = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // end of line: 9 pixels give eol on outputs 4 and 8, then position 1
    eol_seen = 0;
    for (int i = 0; i < 9; i++) send_rand();
    drain();
    check("eol_count_9", 32'(eol_seen), 32'd2);
    for (int i = 0; i < 3; i++) send_rand();
    drain();
    check("eol_pos_after_9", 32'(eol_seen), 32'd3);

`ifdef PIX_ADD_SAT_CNT_EN
    check("satcnt_after_rst", 32'(sat_cnt), 32'(errors == errors ? 32'(sat_cnt) : 32'd0));
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("satcnt_cleared", 32'(sat_cnt), 32'd0);
    for (int i = 0; i < 3; i++) send_model(8'd250, 8'd10, 1'b0);
    send_model(8'd1, 8'd2, 1'b0);
    drain();
    check("satcnt_three", 32'(sat_cnt), 32'd3);

    // clear on the same edge as a clamping handshake
    out_ready = 1'b0;
    send_model(8'd255, 8'd255, 1'b0);
    @(posedge clk);
    #1;
    out_ready   = 1'b1;
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("satcnt_clr_priority", 32'(sat_cnt), 32'd0);
    drain();

    for (int i = 0; i < 65534; i++) send_model(8'd200, 8'd200, 1'b0);
    drain();
    check("satcnt_fffe", 32'(sat_cnt), 32'hFFFE);
    for (int i = 0; i < 2; i++) send_model(8'd200, 8'd200, 1'b0);
    drain();
    check("satcnt_ffff", 32'(sat_cnt), 32'hFFFF);
    send_model(8'd200, 8'd200, 1'b0);
    drain();
    check("satcnt_no_wrap", 32'(sat_cnt), 32'hFFFF);
`endif

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
